// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit: funct3 codes,
// FSM states, the memory size encoding, and legality/alignment checks.
package lsu_pkg;

    localparam int XLEN_C = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Encoding matches memory_management sel_mem_size.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    function automatic logic f3_legal(input logic store, input logic fp,
                                      input logic [2:0] f3);
        if (fp)
            return (f3 == F3_W) || (f3 == F3_D);
        if (store)
            return !f3[2];
        return f3 != 3'b111;
    endfunction

    function automatic logic misaligned(input mem_size_e sz, input logic [2:0] ea_lo);
        case (sz)
            SZ_H:    return ea_lo[0];
            SZ_W:    return |ea_lo[1:0];
            SZ_D:    return |ea_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and memory_management bus of the load/store unit.
// The slave view belongs to the unit; the master view drives it.
interface load_store_unit_if;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_store;
    logic                   req_fp;
    logic [2:0]             req_funct3;
    logic [63:0]            req_base;
    logic [63:0]            req_offset;
    logic [63:0]            req_wdata;

    logic                   resp_valid;
    logic [63:0]            resp_rdata;
    logic                   resp_fault;

    logic                   mm_start;
    logic                   mm_store;
    lsu_pkg::mem_size_e     mm_size;
    logic [63:0]            mm_addr;
    logic [63:0]            mm_wdata;
    logic                   mm_done;
    logic [63:0]            mm_rdata;

    modport slave (
        input  req_valid, req_store, req_fp, req_funct3, req_base, req_offset, req_wdata,
        input  mm_done, mm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mm_start, mm_store, mm_size, mm_addr, mm_wdata
    );

    modport master (
        output req_valid, req_store, req_fp, req_funct3, req_base, req_offset, req_wdata,
        output mm_done, mm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mm_start, mm_store, mm_size, mm_addr, mm_wdata
    );

endinterface

// File: rtl/load_extend.sv
// Load data extension: sign/zero-extends integer loads and NaN-boxes FLW.
// Purely combinational so it can also feed the writeback mux.
module load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic            fp_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = rdata_i;
        if (fp_i) begin
            if (funct3_i == F3_W)
                data_o = {{(XLEN-32){1'b1}}, rdata_i[31:0]};
        end else begin
            case (funct3_i)
                F3_B:    data_o = {{(XLEN-8){rdata_i[7]}},   rdata_i[7:0]};
                F3_H:    data_o = {{(XLEN-16){rdata_i[15]}}, rdata_i[15:0]};
                F3_W:    data_o = {{(XLEN-32){rdata_i[31]}}, rdata_i[31:0]};
                F3_BU:   data_o = {{(XLEN-8){1'b0}},  rdata_i[7:0]};
                F3_HU:   data_o = {{(XLEN-16){1'b0}}, rdata_i[15:0]};
                F3_WU:   data_o = {{(XLEN-32){1'b0}}, rdata_i[31:0]};
                default: data_o = rdata_i;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: forms the effective address, screens legality/alignment,
// runs one start/done transaction on memory_management and returns one response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    lsu_state_e      state_q, state_d;
    logic            store_q, store_d;
    logic            fp_q, fp_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] ext_data;
    logic            in_mm;

    assign ea = bus.req_base + bus.req_offset;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata_i  (bus.mm_rdata),
        .funct3_i (f3_q),
        .fp_i     (fp_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        fp_d    = fp_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    fp_d    = bus.req_fp;
                    f3_d    = bus.req_funct3;
                    addr_d  = ea;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    fault_d = !f3_legal(bus.req_store, bus.req_fp, bus.req_funct3) ||
                              (CHECK_ALIGN &&
                               misaligned(mem_size_e'(bus.req_funct3[1:0]), ea[2:0]));
                    // Faulting requests skip memory entirely.
                    state_d = fault_d ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mm_done) begin
                    rdata_d = store_q ? '0 : ext_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            fp_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            fp_q    <= fp_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Outputs are gated by state so idle/reset values are always zero.
    assign in_mm          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mm_start   = (state_q == ST_ISSUE);
    assign bus.mm_store   = in_mm && store_q;
    assign bus.mm_size    = in_mm ? mem_size_e'(f3_q[1:0]) : SZ_B;
    assign bus.mm_addr    = in_mm ? addr_q  : '0;
    assign bus.mm_wdata   = in_mm ? wdata_q : '0;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.resp_fault = (state_q == ST_RESP) && fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: hand-computed vectors checked with
// immediate assertions at each observation point.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   starts = 0;

    load_store_unit_if bus();

    load_store_unit #(.XLEN(64), .CHECK_ALIGN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mm_start === 1'b1) starts++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic st, input logic fp, input logic [2:0] f3,
                             input logic [63:0] base, input logic [63:0] off,
                             input logic [63:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_fp     = fp;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
    endtask

    // Full transaction: accept, ISSUE, WAIT (+busy cycles), done, RESP, back to IDLE.
    task automatic mem_op(input string tag, input logic st, input logic fp, input logic [2:0] f3,
                          input logic [63:0] base, input logic [63:0] off, input logic [63:0] wd,
                          input logic [63:0] rd, input logic [63:0] exp_addr,
                          input logic [1:0] exp_size, input logic [63:0] exp_rd, input int busy);
        int s0;
        s0 = starts;
        drive_req(st, fp, f3, base, off, wd);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, ".start"}, 64'(bus.mm_start), 64'd1);
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, ".addr"},  bus.mm_addr, exp_addr);
        chk({tag, ".size"},  64'(bus.mm_size), 64'(exp_size));
        chk({tag, ".store"}, 64'(bus.mm_store), 64'(st));
        if (st) chk({tag, ".wdata"}, bus.mm_wdata, wd);
        @(posedge clk); #1;
        chk({tag, ".start_wait"}, 64'(bus.mm_start), 64'd0);
        for (int i = 0; i < busy; i++) begin
            @(posedge clk); #1;
            chk({tag, ".addr_hold"}, bus.mm_addr, exp_addr);
            chk({tag, ".novalid"},   64'(bus.resp_valid), 64'd0);
        end
        bus.mm_rdata = rd;
        bus.mm_done  = 1'b1;
        @(posedge clk); #1;
        bus.mm_done  = 1'b0;
        bus.mm_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, ".resp_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, ".resp_fault"}, 64'(bus.resp_fault), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".resp_pulse"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ".idle_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, ".one_start"},  64'(starts - s0), 64'd1);
    endtask

    // Faulting request: response one cycle after accept, no memory access.
    task automatic fault_op(input string tag, input logic st, input logic fp, input logic [2:0] f3,
                            input logic [63:0] base, input logic [63:0] off);
        int s0;
        s0 = starts;
        drive_req(st, fp, f3, base, off, 64'hDEAD_BEEF_0000_0001);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, ".resp_fault"}, 64'(bus.resp_fault), 64'd1);
        chk({tag, ".resp_rdata"}, bus.resp_rdata, 64'd0);
        chk({tag, ".start"},      64'(bus.mm_start), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".resp_pulse"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ".no_start"},   64'(starts - s0), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_fp     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_base   = '0;
        bus.req_offset = '0;
        bus.req_wdata  = '0;
        bus.mm_done    = 1'b0;
        bus.mm_rdata   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",      64'(bus.req_ready), 64'd1);
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst.mm_start",   64'(bus.mm_start), 64'd0);
        chk("rst.mm_addr",    bus.mm_addr, 64'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem_op("lb", 1'b0, 1'b0, 3'b000, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
               64'h1234_5678_9ABC_DE80, 64'hFF, 2'd0, 64'hFFFF_FFFF_FFFF_FF80, 0);
        mem_op("lhu", 1'b0, 1'b0, 3'b101, 64'h200, 64'h2, 64'd0,
               64'hDEAD_BEEF_CAFE_8001, 64'h202, 2'd1, 64'h0000_0000_0000_8001, 2);
        fault_op("sw_mis", 1'b1, 1'b0, 3'b010, 64'h300, 64'h1);
        mem_op("flw", 1'b0, 1'b1, 3'b010, 64'h500, 64'h4, 64'd0,
               64'h0123_4567_3F80_0000, 64'h504, 2'd2, 64'hFFFF_FFFF_3F80_0000, 1);
        mem_op("sd", 1'b1, 1'b0, 3'b011, 64'h400, 64'h8, 64'h1122_3344_5566_7788,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h408, 2'd3, 64'd0, 3);
        mem_op("lw", 1'b0, 1'b0, 3'b010, 64'h8, 64'h8, 64'd0,
               64'h7777_7777_8000_0001, 64'h10, 2'd2, 64'hFFFF_FFFF_8000_0001, 0);
        mem_op("lwu", 1'b0, 1'b0, 3'b110, 64'h8, 64'h8, 64'd0,
               64'h7777_7777_8000_0001, 64'h10, 2'd2, 64'h0000_0000_8000_0001, 0);
        mem_op("lh", 1'b0, 1'b0, 3'b001, 64'h0, 64'h6, 64'd0,
               64'h0000_0000_0000_FF7F, 64'h6, 2'd1, 64'hFFFF_FFFF_FFFF_FF7F, 0);
        mem_op("lbu_odd", 1'b0, 1'b0, 3'b100, 64'h10, 64'h3, 64'd0,
               64'hFFFF_FFFF_FFFF_FF80, 64'h13, 2'd0, 64'h0000_0000_0000_0080, 0);
        mem_op("fld", 1'b0, 1'b1, 3'b011, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0,
               64'h8123_4567_89AB_CDEF, 64'hFF8, 2'd3, 64'h8123_4567_89AB_CDEF, 0);
        mem_op("sb_odd", 1'b1, 1'b0, 3'b000, 64'h20, 64'h1, 64'h0000_0000_0000_00AB,
               64'd0, 64'h21, 2'd0, 64'd0, 0);

        fault_op("ld_f3_111", 1'b0, 1'b0, 3'b111, 64'h40, 64'h0);
        fault_op("fp_f3_000", 1'b0, 1'b1, 3'b000, 64'h40, 64'h0);
        fault_op("st_f3_100", 1'b1, 1'b0, 3'b100, 64'h40, 64'h0);
        fault_op("ld_mis",    1'b0, 1'b0, 3'b011, 64'h400, 64'h4);
        fault_op("lh_mis",    1'b0, 1'b0, 3'b001, 64'h41, 64'h0);

        // Stray completion while idle must not produce a response.
        bus.mm_done = 1'b1;
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
        chk("stray.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("stray.ready",      64'(bus.req_ready), 64'd1);

        // Reset while waiting on memory, then a late completion.
        drive_req(1'b0, 1'b0, 3'b011, 64'h800, 64'h0, 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid.in_wait_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid.ready",   64'(bus.req_ready), 64'd1);
        chk("mid.mm_addr", bus.mm_addr, 64'd0);
        chk("mid.start",   64'(bus.mm_start), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mm_rdata = 64'h1;
        bus.mm_done  = 1'b1;
        @(posedge clk); #1;
        bus.mm_done  = 1'b0;
        chk("late.resp_valid0", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        chk("late.resp_valid1", 64'(bus.resp_valid), 64'd0);
        chk("late.ready",       64'(bus.req_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
